// File: rtl/sym9_pkg.sv
// Shared constants and buffer-state type for the sym9 popcount scheduler.
package sym9_pkg;
  localparam int SYM9_W = 9;
  localparam int CNT_W  = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_e;
endpackage

// File: rtl/sym9_eval.sv
// Combinational popcount of one 9-bit operand plus an inclusive [LO, HI] range match.
module sym9_eval
  import sym9_pkg::*;
#(
  parameter int LO = 3,
  parameter int HI = 6
) (
  input  logic [SYM9_W-1:0] operand_i,
  output logic [CNT_W-1:0]  count_o,
  output logic              match_o
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    count_o = '0;
    for (int b = 0; b < SYM9_W; b++) begin
      count_o = count_o + CNT_W'(operand_i[b]);
    end
    match_o = (int'(count_o) >= LO) && (int'(count_o) <= HI);
  end

endmodule

// File: rtl/sym9_sched.sv
// Round-robin arbiter feeding one shared popcount evaluator into a single-entry
// result buffer; accepts a new request whenever the buffer is empty or draining.
module sym9_sched
  import sym9_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LO   = 3,
  parameter int HI   = 6,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [SYM9_W*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ID_W-1:0]          resp_id,
  output logic                     resp_match,
  output logic [CNT_W-1:0]         resp_count,
  output logic [15:0]              acc_cnt
);

  if (NREQ < 2 || NREQ > 8 || LO < 0 || LO > HI || HI > SYM9_W) begin : g_param_err
    $error("sym9_sched: illegal NREQ/LO/HI parameters");
  end

  buf_state_e         state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [15:0]        acc_q, acc_d;

  logic [ID_W-1:0]    grant;
  logic               found;
  logic               accept;
  logic [SYM9_W-1:0]  operand;
  logic [CNT_W-1:0]   eval_count;
  logic               eval_match;

  // Two passes: first requester at or above rr_ptr, else wrap to the lowest one.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i] && (ID_W'(i) >= rr_ptr_q)) begin
        found = 1'b1;
        grant = ID_W'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i]) begin
        found = 1'b1;
        grant = ID_W'(i);
      end
    end
  end

  assign accept = !rst && found && ((state_q == EMPTY) || resp_ready);

  always_comb begin
    operand   = '0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == ID_W'(i)) begin
        operand      = req_data[i*SYM9_W +: SYM9_W];
        req_ready[i] = accept;
      end
    end
  end

  sym9_eval #(
    .LO (LO),
    .HI (HI)
  ) u_eval (
    .operand_i (operand),
    .count_o   (eval_count),
    .match_o   (eval_match)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    match_d  = match_q;
    count_d  = count_q;
    acc_d    = acc_q;
    if (accept) begin
      state_d  = FULL;
      rr_ptr_d = (grant == ID_W'(NREQ - 1)) ? '0 : grant + ID_W'(1);
      id_d     = grant;
      match_d  = eval_match;
      count_d  = eval_count;
      acc_d    = acc_q + 16'd1;
    end else if ((state_q == FULL) && resp_ready) begin
      state_d = EMPTY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      rr_ptr_q <= '0;
      id_q     <= '0;
      match_q  <= 1'b0;
      count_q  <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      match_q  <= match_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
    end
  end

  assign resp_valid = (state_q == FULL);
  assign resp_id    = id_q;
  assign resp_match = match_q;
  assign resp_count = count_q;
  assign acc_cnt    = acc_q;

endmodule

// File: tb/tb_sym9_sched.sv
// Directed self-checking bench for sym9_sched with hand-computed expectations.
module tb_sym9_sched;
  localparam int NREQ = 4;

  logic             clk;
  logic             rst;
  logic [NREQ-1:0]  req_valid;
  logic [9*NREQ-1:0] req_data;
  logic [NREQ-1:0]  req_ready;
  logic             resp_valid;
  logic             resp_ready;
  logic [1:0]       resp_id;
  logic             resp_match;
  logic [3:0]       resp_count;
  logic [15:0]      acc_cnt;

  int n_chk;
  int n_err;

  sym9_sched #(.NREQ(NREQ), .LO(3), .HI(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_match (resp_match),
    .resp_count (resp_count),
    .acc_cnt    (acc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Per-requester operands for the round-robin runs: counts 1,4,8,6 / match 0,1,0,1.
  logic [8:0] rr_data  [NREQ] = '{9'h001, 9'h00F, 9'h0FF, 9'h03F};
  logic [3:0] rr_cnt   [NREQ] = '{4'd1, 4'd4, 4'd8, 4'd6};
  logic       rr_match [NREQ] = '{1'b0, 1'b1, 1'b0, 1'b1};

  logic [8:0] bnd_data  [4] = '{9'h003, 9'h03F, 9'h07F, 9'h1FF};
  logic [3:0] bnd_cnt   [4] = '{4'd2, 4'd6, 4'd7, 4'd9};
  logic       bnd_match [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  task automatic load_rr_data();
    for (int i = 0; i < NREQ; i++) req_data[9*i +: 9] = rr_data[i];
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    req_valid = 4'b1111;
    req_data = '0;
    resp_ready = 1'b1;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    step();
    step();
    req_valid = 4'b0000;
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_id", 32'(resp_id), 32'h0);
    check("rst_resp_count", 32'(resp_count), 32'h0);
    check("rst_resp_match", 32'(resp_match), 32'h0);
    check("rst_acc_cnt", 32'(acc_cnt), 32'h0);
    rst = 1'b0;

    // First transaction
    req_valid = 4'b0001;
    req_data[8:0] = 9'b000000111;
    #1;
    check("t1_req_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 4'b0000;
    check("t1_resp_valid", 32'(resp_valid), 32'h1);
    check("t1_resp_id", 32'(resp_id), 32'h0);
    check("t1_resp_count", 32'(resp_count), 32'h3);
    check("t1_resp_match", 32'(resp_match), 32'h1);
    check("t1_acc_cnt", 32'(acc_cnt), 32'h1);
    step();
    check("t1_drain_empty", 32'(resp_valid), 32'h0);

    // Match boundaries via requester 1
    for (int k = 0; k < 4; k++) begin
      req_valid = 4'b0010;
      req_data[17:9] = bnd_data[k];
      #1;
      check($sformatf("bnd%0d_req_ready", k), 32'(req_ready), 32'h2);
      step();
      req_valid = 4'b0000;
      check($sformatf("bnd%0d_id", k), 32'(resp_id), 32'h1);
      check($sformatf("bnd%0d_count", k), 32'(resp_count), 32'(bnd_cnt[k]));
      check($sformatf("bnd%0d_match", k), 32'(resp_match), 32'(bnd_match[k]));
    end
    check("bnd_acc_cnt", 32'(acc_cnt), 32'd5);
    step();
    check("bnd_drain_empty", 32'(resp_valid), 32'h0);

    // Reset, then full round-robin with no bubbles
    rst = 1'b1;
    step();
    rst = 1'b0;
    load_rr_data();
    req_valid = 4'b1111;
    resp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      check($sformatf("rr%0d_req_ready", c), 32'(req_ready), 32'(1 << (c % 4)));
      step();
      check($sformatf("rr%0d_valid", c), 32'(resp_valid), 32'h1);
      check($sformatf("rr%0d_id", c), 32'(resp_id), 32'(c % 4));
      check($sformatf("rr%0d_count", c), 32'(resp_count), 32'(rr_cnt[c % 4]));
      check($sformatf("rr%0d_match", c), 32'(resp_match), 32'(rr_match[c % 4]));
    end
    check("rr_acc_cnt", 32'(acc_cnt), 32'd8);

    // Backpressure: FULL with resp_ready low holds everything
    resp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("bp%0d_req_ready", c), 32'(req_ready), 32'h0);
      step();
      check($sformatf("bp%0d_valid", c), 32'(resp_valid), 32'h1);
      check($sformatf("bp%0d_id", c), 32'(resp_id), 32'h3);
      check($sformatf("bp%0d_count", c), 32'(resp_count), 32'h6);
      check($sformatf("bp%0d_acc", c), 32'(acc_cnt), 32'd8);
    end
    resp_ready = 1'b1;
    #1;
    check("bp_release_req_ready", 32'(req_ready), 32'h1);
    step();
    check("bp_release_valid", 32'(resp_valid), 32'h1);
    check("bp_release_id", 32'(resp_id), 32'h0);
    check("bp_release_count", 32'(resp_count), 32'h1);
    check("bp_release_acc", 32'(acc_cnt), 32'd9);

    // Reset mid-operation: reach FULL with acc_cnt=5 and rr_ptr=3
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid = 4'b1111;
    resp_ready = 1'b1;
    repeat (4) step();
    req_valid = 4'b0100;
    step();
    req_valid = 4'b0000;
    resp_ready = 1'b0;
    step();
    check("mid_full_valid", 32'(resp_valid), 32'h1);
    check("mid_full_id", 32'(resp_id), 32'h2);
    check("mid_full_acc", 32'(acc_cnt), 32'd5);
    rst = 1'b1;
    req_valid = 4'b1010;
    resp_ready = 1'b1;
    #1;
    check("mid_rst_req_ready", 32'(req_ready), 32'h0);
    step();
    rst = 1'b0;
    check("mid_rst_valid", 32'(resp_valid), 32'h0);
    check("mid_rst_acc", 32'(acc_cnt), 32'h0);
    check("mid_rst_id", 32'(resp_id), 32'h0);
    #1;
    check("mid_post_req_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = 4'b0000;
    check("mid_post_id", 32'(resp_id), 32'h1);
    check("mid_post_acc", 32'(acc_cnt), 32'h1);

    // Accept counter wrap
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid = 4'b1111;
    resp_ready = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    check("wrap_acc_max", 32'(acc_cnt), 32'hFFFF);
    step();
    check("wrap_acc_zero", 32'(acc_cnt), 32'h0);
    req_valid = 4'b0000;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
